// File: rtl/hazard_ctrl.sv
// Decode-stage hazard unit: register compare strobes, load-use/branch stalls, mul/div HI/LO tracking.
// Define HAZARD_MULDIV_EN to build the mul/div FSM; otherwise md_busy/md_done/mdstall are tied low.
module hazard_ctrl #(
    parameter int REG_W     = 5,
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeregE,
    input  logic [REG_W-1:0] writeregM,
    input  logic [REG_W-1:0] writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             md_startE,
    input  logic             md_readD,
    output logic             rs_D,
    output logic             rt_D,
    output logic             rs_E,
    output logic             rt_E,
    output logic             rs_wr_DE,
    output logic             rt_wr_DE,
    output logic             rs_wr_DM,
    output logic             rt_wr_DM,
    output logic             rs_wr_EM,
    output logic             rt_wr_EM,
    output logic             rs_wr_EW,
    output logic             rt_wr_EW,
    output logic             stallF,
    output logic             stallD,
    output logic             flushE,
    output logic             md_busy,
    output logic             md_done
);

    logic lwstall;
    logic brstall;
    logic mdstall;
    logic stall;

    assign rs_D = |rsD;
    assign rt_D = |rtD;
    assign rs_E = |rsE;
    assign rt_E = |rtE;

    // Pure equality; the consumer qualifies with regwrite where it needs to.
    assign rs_wr_DE = (rsD == writeregE);
    assign rt_wr_DE = (rtD == writeregE);
    assign rs_wr_DM = (rsD == writeregM);
    assign rt_wr_DM = (rtD == writeregM);
    assign rs_wr_EM = (rsE == writeregM);
    assign rt_wr_EM = (rtE == writeregM);
    assign rs_wr_EW = (rsE == writeregW);
    assign rt_wr_EW = (rtE == writeregW);

    assign lwstall = memtoregE & regwriteE & ((rs_D & rs_wr_DE) | (rt_D & rt_wr_DE));

    assign brstall = branchD & ((regwriteE & ((rs_D & rs_wr_DE) | (rt_D & rt_wr_DE)))
                              | (memtoregM & ((rs_D & rs_wr_DM) | (rt_D & rt_wr_DM))));

    assign stall  = lwstall | brstall | mdstall;
    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;

`ifdef HAZARD_MULDIV_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A start pulse in any state (re)loads the counter; restart beats completion.
    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (md_startE) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (md_startE) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (md_startE) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_busy = (state_q == BUSY);
    assign md_done = (state_q == DONE);
    assign mdstall = md_readD & (state_q != IDLE);
`else
    logic unused_md;

    assign unused_md = ^{clk, reset, md_startE, md_readD, CNT_W'(MD_CYCLES)};
    assign md_busy   = 1'b0;
    assign md_done   = 1'b0;
    assign mdstall   = 1'b0;
`endif

    logic unused_wb;

    // regwriteM/W are part of the forwarding contract but not needed for any stall term.
    assign unused_wb = regwriteM ^ regwriteW;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; mul/div expectations follow HAZARD_MULDIV_EN.
module tb_hazard_ctrl;

    localparam int REG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] rsD, rtD, rsE, rtE;
    logic [REG_W-1:0] writeregE, writeregM, writeregW;
    logic             regwriteE, regwriteM, regwriteW;
    logic             memtoregE, memtoregM;
    logic             branchD, md_startE, md_readD;
    logic             rs_D, rt_D, rs_E, rt_E;
    logic             rs_wr_DE, rt_wr_DE, rs_wr_DM, rt_wr_DM;
    logic             rs_wr_EM, rt_wr_EM, rs_wr_EW, rt_wr_EW;
    logic             stallF, stallD, flushE;
    logic             md_busy, md_done;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(
        .REG_W    (REG_W),
        .MD_CYCLES(32),
        .CNT_W    (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rsD      (rsD),
        .rtD      (rtD),
        .rsE      (rsE),
        .rtE      (rtE),
        .writeregE(writeregE),
        .writeregM(writeregM),
        .writeregW(writeregW),
        .regwriteE(regwriteE),
        .regwriteM(regwriteM),
        .regwriteW(regwriteW),
        .memtoregE(memtoregE),
        .memtoregM(memtoregM),
        .branchD  (branchD),
        .md_startE(md_startE),
        .md_readD (md_readD),
        .rs_D     (rs_D),
        .rt_D     (rt_D),
        .rs_E     (rs_E),
        .rt_E     (rt_E),
        .rs_wr_DE (rs_wr_DE),
        .rt_wr_DE (rt_wr_DE),
        .rs_wr_DM (rs_wr_DM),
        .rt_wr_DM (rt_wr_DM),
        .rs_wr_EM (rs_wr_EM),
        .rt_wr_EM (rt_wr_EM),
        .rs_wr_EW (rs_wr_EW),
        .rt_wr_EW (rt_wr_EW),
        .stallF   (stallF),
        .stallD   (stallD),
        .flushE   (flushE),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0;
        branchD = 1'b0; md_startE = 1'b0; md_readD = 1'b0;
    endtask

    task automatic check_stall(input string tag, input logic exp);
        check({tag, "_stallF"}, stallF, exp);
        check({tag, "_stallD"}, stallD, exp);
        check({tag, "_flushE"}, flushE, exp);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("rst_busy", md_busy, 0);
        check("rst_done", md_done, 0);
        check_stall("rst", 0);
        check("rst_rs_D", rs_D, 0);
        reset = 1'b0;
        tick();

        // T1: load-use hazard, then register 0 never stalls
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd8; rsD = 5'd8;
        #1;
        check("t1_rs_D", rs_D, 1);
        check("t1_rs_wr_DE", rs_wr_DE, 1);
        check("t1_rt_wr_DE", rt_wr_DE, 0);
        check_stall("t1_lw", 1);
        rsD = 5'd0; writeregE = 5'd0;
        #1;
        check("t1_rs_D0", rs_D, 0);
        check("t1_rs_wr_DE0", rs_wr_DE, 1);
        check("t1_rt_wr_DE0", rt_wr_DE, 1);
        check_stall("t1_r0", 0);
        rtD = 5'd3; writeregE = 5'd3;
        #1;
        check_stall("t1_lw_rt", 1);
        memtoregE = 1'b0;
        #1;
        check_stall("t1_nolw", 0);

        // T2: branch hazards against E (ALU) and M (load)
        clear_inputs();
        branchD = 1'b1; rtD = 5'd9; writeregE = 5'd9; regwriteE = 1'b1;
        #1;
        check_stall("t2_brE", 1);
        regwriteE = 1'b0; writeregM = 5'd9; memtoregM = 1'b1;
        #1;
        check("t2_rt_wr_DM", rt_wr_DM, 1);
        check_stall("t2_brM", 1);
        memtoregM = 1'b0; regwriteM = 1'b1;
        #1;
        check_stall("t2_brM_alu", 0);
        check("t2_rt_wr_DM_b", rt_wr_DM, 1);
        branchD = 1'b0; regwriteE = 1'b1; memtoregM = 1'b1;
        #1;
        check_stall("t2_nobr", 0);

        // Execute-stage compare strobes and Decode-vs-M rs strobe
        clear_inputs();
        rsE = 5'd5; rtE = 5'd6; writeregM = 5'd5; writeregW = 5'd6; rsD = 5'd12;
        #1;
        check("ex_rs_E", rs_E, 1);
        check("ex_rt_E", rt_E, 1);
        check("ex_rs_wr_EM", rs_wr_EM, 1);
        check("ex_rt_wr_EM", rt_wr_EM, 0);
        check("ex_rs_wr_EW", rs_wr_EW, 0);
        check("ex_rt_wr_EW", rt_wr_EW, 1);
        check("ex_rs_wr_DM", rs_wr_DM, 0);
        writeregM = 5'd12; rsE = 5'd0;
        #1;
        check("ex_rs_wr_DM_b", rs_wr_DM, 1);
        check("ex_rs_E0", rs_E, 0);
        check("ex_rs_wr_EM_b", rs_wr_EM, 0);
        clear_inputs();
        tick();

`ifdef HAZARD_MULDIV_EN
        // T3: single operation, busy cycles 1..32, done at 33
        md_startE = 1'b1;
        tick();
        md_startE = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            md_readD = (c == 10);
            #1;
            check($sformatf("t3_busy_c%0d", c), md_busy, 1);
            check($sformatf("t3_done_c%0d", c), md_done, 0);
            if (c == 10) check("t3_stall_c10", stallD, 1);
            md_readD = 1'b0;
            tick();
        end
        check("t3_busy_c33", md_busy, 0);
        check("t3_done_c33", md_done, 1);
        md_readD = 1'b1;
        #1;
        check("t3_stall_c33", stallD, 1);
        md_readD = 1'b0;
        tick();
        md_readD = 1'b1;
        #1;
        check("t3_done_c34", md_done, 0);
        check("t3_stall_c34", stallD, 0);
        md_readD = 1'b0;
        tick();

        // T4a: restart at cycle 20 extends busy through 52, done at 53
        md_startE = 1'b1;
        tick();
        md_startE = 1'b0;
        repeat (19) tick();
        md_startE = 1'b1;
        #1;
        check("t4_busy_c20", md_busy, 1);
        tick();
        md_startE = 1'b0;
        for (int c = 21; c <= 52; c++) begin
            #1;
            check($sformatf("t4_busy_c%0d", c), {md_busy, md_done}, 2'b10);
            tick();
        end
        check("t4_done_c53", {md_busy, md_done}, 2'b01);
        tick();
        check("t4_idle_c54", {md_busy, md_done}, 2'b00);

        // T4b: restart coincident with cnt==0 suppresses the done pulse
        md_startE = 1'b1;
        tick();
        md_startE = 1'b0;
        repeat (31) tick();
        md_startE = 1'b1;
        tick();
        md_startE = 1'b0;
        for (int c = 33; c <= 64; c++) begin
            #1;
            check($sformatf("t4b_busy_c%0d", c), {md_busy, md_done}, 2'b10);
            tick();
        end
        check("t4b_done_c65", {md_busy, md_done}, 2'b01);
        tick();

        // T5: reset mid-operation discards the result; compare strobes ignore reset
        md_startE = 1'b1;
        tick();
        md_startE = 1'b0;
        repeat (14) tick();
        reset = 1'b1; rsE = 5'd7; writeregM = 5'd7;
        #1;
        check("t5_rs_wr_EM_rst", rs_wr_EM, 1);
        check("t5_rs_E_rst", rs_E, 1);
        tick();
        reset = 1'b0;
        check("t5_busy_after", md_busy, 0);
        check("t5_done_after", md_done, 0);
        md_readD = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            check($sformatf("t5_quiet_%0d", c), {md_busy, md_done, stallD}, 3'b000);
            tick();
        end
        clear_inputs();
`else
        // T6: mul/div disabled, start and read are ignored
        md_startE = 1'b1; md_readD = 1'b1;
        #1;
        check("t6_stall_start", stallD, 0);
        tick();
        md_startE = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            check($sformatf("t6_quiet_%0d", c), {md_busy, md_done, stallF, stallD, flushE}, 5'b00000);
            tick();
        end
        clear_inputs();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
